// File: rtl/fu_control_sequencer.sv
// Purpose : control-word sequencer; turns packed instructions into FS/AA/BA/DA/rw for the function unit.
// Latency : accept at edge k, first write in cycle k+1, done on write RPT+1; next accept one cycle later.
// Backpres: instr_ready high only in IDLE; an offer made while busy is ignored and must be held.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   instr_valid/ready    instruction handshake; instr = {FS[4:0],DA,AA,BA,RPT,FW,RSV}
//   alu_flag             function-unit flags {V,N,Z,C}, sampled at the end of the done cycle
//   fs, aa, ba, da       registered function select and register-file addresses
//   rw, done             write enable and final-write pulse (decoded from state/counter)
//   flag_q               registered flags {V,N,Z,C}
//   trap                 present only when SEQ_TRAP_EN is defined; sticky illegal-instruction flag
// Build option: SEQ_TRAP_EN enables RSV=1 illegal-instruction trapping.

module fu_control_sequencer #(
   parameter  int AW    = 2,
   parameter  int RPT_W = 3,
   localparam int IW    = 5 + 3*AW + RPT_W + 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          instr_valid,
   output logic          instr_ready,
   input  logic [IW-1:0] instr,
   input  logic [3:0]    alu_flag,
   output logic [4:0]    fs,
   output logic [AW-1:0] aa,
   output logic [AW-1:0] ba,
   output logic [AW-1:0] da,
   output logic          rw,
   output logic          done,
`ifdef SEQ_TRAP_EN
   output logic          trap,
`endif
   output logic [3:0]    flag_q
);

   localparam int DA_LSB  = IW - 5 - AW;
   localparam int AA_LSB  = DA_LSB - AW;
   localparam int BA_LSB  = AA_LSB - AW;
   localparam int RPT_LSB = BA_LSB - RPT_W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXEC   = 2'd1,
      REPEAT = 2'd2,
      TRAP   = 2'd3
   } state_t;

   state_t             state;
   logic [RPT_W-1:0]   rpt_q;
   logic [RPT_W-1:0]   cnt;
   logic               fw_q;

   logic [4:0]         i_fs;
   logic [AW-1:0]      i_da, i_aa, i_ba;
   logic [RPT_W-1:0]   i_rpt;
   logic               i_fw;
   logic               i_rsv;

   assign i_fs  = instr[IW-1 -: 5];
   assign i_da  = instr[DA_LSB +: AW];
   assign i_aa  = instr[AA_LSB +: AW];
   assign i_ba  = instr[BA_LSB +: AW];
   assign i_rpt = instr[RPT_LSB +: RPT_W];
   assign i_fw  = instr[1];
   assign i_rsv = instr[0];

   // Without trapping the reserved bit carries no meaning.
`ifndef SEQ_TRAP_EN
   logic rsv_unused;
   assign rsv_unused = i_rsv;
`endif

   assign instr_ready = (state == IDLE);
   assign rw          = (state == EXEC) || (state == REPEAT);
   // EXEC is the last write only when no repeats follow; in REPEAT the count of 1 marks the last pass.
   assign done        = ((state == EXEC) && (rpt_q == '0)) ||
                        ((state == REPEAT) && (cnt == RPT_W'(1)));
`ifdef SEQ_TRAP_EN
   assign trap        = (state == TRAP);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         fs     <= '0;
         aa     <= '0;
         ba     <= '0;
         da     <= '0;
         rpt_q  <= '0;
         cnt    <= '0;
         fw_q   <= 1'b0;
         flag_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (instr_valid) begin
`ifdef SEQ_TRAP_EN
                  if (i_rsv) begin
                     // Illegal op is consumed but nothing about it is executed or recorded.
                     state <= TRAP;
                  end else
`endif
                  begin
                     fs    <= i_fs;
                     aa    <= i_aa;
                     ba    <= i_ba;
                     da    <= i_da;
                     rpt_q <= i_rpt;
                     fw_q  <= i_fw;
                     state <= EXEC;
                  end
               end
            end
            EXEC: begin
               if (rpt_q == '0) begin
                  state <= IDLE;
               end else begin
                  // Repeats read the destination on both ports so each pass chains on the last result.
                  cnt   <= rpt_q;
                  aa    <= da;
                  ba    <= da;
                  state <= REPEAT;
               end
            end
            REPEAT: begin
               cnt <= cnt - RPT_W'(1);
               if (cnt == RPT_W'(1))
                  state <= IDLE;
            end
            default: begin
`ifdef SEQ_TRAP_EN
               state <= TRAP;
`else
               state <= IDLE;
`endif
            end
         endcase

         if (done && fw_q)
            flag_q <= alu_flag;
      end
   end

endmodule

// File: tb/tb_fu_control_sequencer.sv
// Directed bench for fu_control_sequencer: reset, single op with flags, repeat chain with a held
// second offer, maximum repeat count, reset abort, and the reserved-bit behaviour of the build.
module tb_fu_control_sequencer;

   logic        clk;
   logic        rst_n;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic [3:0]  alu_flag;
   logic [4:0]  fs;
   logic [1:0]  aa, ba, da;
   logic        rw;
   logic        done;
   logic [3:0]  flag_q;
`ifdef SEQ_TRAP_EN
   logic        trap;
`endif

   int checks = 0;
   int errors = 0;

   fu_control_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .alu_flag    (alu_flag),
      .fs          (fs),
      .aa          (aa),
      .ba          (ba),
      .da          (da),
      .rw          (rw),
      .done        (done),
`ifdef SEQ_TRAP_EN
      .trap        (trap),
`endif
      .flag_q      (flag_q)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle 2 time units past the rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   int writes;
   int dones;

   initial begin
      rst_n       = 1'b0;
      instr_valid = 1'b0;
      instr       = 16'h0000;
      alu_flag    = 4'h0;

      // ---------------- reset state ----------------
      #12;
      check("rst_ready",  32'(instr_ready), 32'd1);
      check("rst_rw",     32'(rw),          32'd0);
      check("rst_done",   32'(done),        32'd0);
      check("rst_flag_q", 32'(flag_q),      32'h0);
      check("rst_fs",     32'(fs),          32'h00);
      check("rst_addr",   32'({aa, ba, da}), 32'h0);
      #10 rst_n = 1'b1;
      tick();
      check("idle_ready", 32'(instr_ready), 32'd1);

      // ---------------- single op 1362 ----------------
      instr       = 16'h1362;
      instr_valid = 1'b1;
      alu_flag    = 4'b0101;
      tick();
      instr_valid = 1'b0;
      check("op1_fs",    32'(fs),          32'h02);
      check("op1_aa",    32'(aa),          32'd2);
      check("op1_ba",    32'(ba),          32'd3);
      check("op1_da",    32'(da),          32'd1);
      check("op1_rw",    32'(rw),          32'd1);
      check("op1_done",  32'(done),        32'd1);
      check("op1_ready", 32'(instr_ready), 32'd0);
      tick();
      check("op1_flag_q", 32'(flag_q),      32'b0101);
      check("op1_ready2", 32'(instr_ready), 32'd1);
      check("op1_rw_off", 32'(rw),          32'd0);
      check("op1_fs_hold", 32'(fs),         32'h02);

      // ---------------- repeat 944C with a held second offer ----------------
      instr       = 16'h944C;
      instr_valid = 1'b1;
      tick();
      // Next instruction offered immediately and held while the repeat runs.
      instr    = 16'h2E82;
      alu_flag = 4'b1111;
      check("rp_c1_fs",   32'(fs),   32'h12);
      check("rp_c1_aa",   32'(aa),   32'd0);
      check("rp_c1_ba",   32'(ba),   32'd2);
      check("rp_c1_da",   32'(da),   32'd2);
      check("rp_c1_rw",   32'(rw),   32'd1);
      check("rp_c1_done", 32'(done), 32'd0);
      tick();
      check("rp_c2_aaba", 32'({aa, ba}), 32'({2'd2, 2'd2}));
      check("rp_c2_rw",   32'(rw),   32'd1);
      check("rp_c2_done", 32'(done), 32'd0);
      check("rp_c2_ready", 32'(instr_ready), 32'd0);
      tick();
      check("rp_c3_rw",   32'(rw),   32'd1);
      check("rp_c3_done", 32'(done), 32'd0);
      check("rp_c3_fs",   32'(fs),   32'h12);
      tick();
      check("rp_c4_rw",   32'(rw),   32'd1);
      check("rp_c4_done", 32'(done), 32'd1);
      check("rp_c4_aaba", 32'({aa, ba}), 32'({2'd2, 2'd2}));
      tick();
      check("rp_idle_ready", 32'(instr_ready), 32'd1);
      check("rp_idle_rw",    32'(rw),          32'd0);
      check("rp_flag_keep",  32'(flag_q),      32'b0101);
      check("bp_not_taken",  32'(fs),          32'h12);
      tick();
      instr_valid = 1'b0;
      alu_flag    = 4'b1010;
      check("bp_fs",   32'(fs),   32'h05);
      check("bp_aa",   32'(aa),   32'd1);
      check("bp_ba",   32'(ba),   32'd0);
      check("bp_da",   32'(da),   32'd3);
      check("bp_done", 32'(done), 32'd1);
      tick();
      check("bp_flag_q", 32'(flag_q), 32'b1010);

      // ---------------- maximum repeat count: 8 writes ----------------
      instr       = 16'h001C;
      instr_valid = 1'b1;
      alu_flag    = 4'b0001;
      tick();
      instr_valid = 1'b0;
      writes = 0;
      dones  = 0;
      for (int i = 0; i < 20; i++) begin
         if (rw)   writes++;
         if (done) dones++;
         if (done || !rw) break;
         tick();
      end
      check("max_writes", 32'(writes), 32'd8);
      check("max_dones",  32'(dones),  32'd1);
      tick();
      check("max_ready",  32'(instr_ready), 32'd1);
      check("max_flag_keep", 32'(flag_q), 32'b1010);

      // ---------------- reset abort in REPEAT ----------------
      instr       = 16'h944C;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      tick();
      tick();
      check("ab_rw_before", 32'(rw), 32'd1);
      rst_n = 1'b0;
      #1;
      check("ab_rw",     32'(rw),          32'd0);
      check("ab_done",   32'(done),        32'd0);
      check("ab_ready",  32'(instr_ready), 32'd1);
      check("ab_flag_q", 32'(flag_q),      32'h0);
      #4 rst_n = 1'b1;
      tick();
      check("ab_idle_ready", 32'(instr_ready), 32'd1);
      check("ab_idle_rw",    32'(rw),          32'd0);
      check("ab_idle_fs",    32'(fs),          32'h00);

      // ---------------- reserved bit ----------------
      instr       = 16'h1363;
      instr_valid = 1'b1;
      alu_flag    = 4'b0011;
      tick();
      instr_valid = 1'b0;
`ifdef SEQ_TRAP_EN
      check("tr_rw",   32'(rw),   32'd0);
      check("tr_done", 32'(done), 32'd0);
      for (int i = 0; i < 12; i++) begin
         check("tr_trap",  32'(trap),        32'd1);
         check("tr_ready", 32'(instr_ready), 32'd0);
         check("tr_rw_hold", 32'(rw),        32'd0);
         tick();
      end
      check("tr_flag_keep", 32'(flag_q), 32'h0);
      rst_n = 1'b0;
      #1;
      check("tr_clear",       32'(trap),        32'd0);
      check("tr_ready_reset", 32'(instr_ready), 32'd1);
      #4 rst_n = 1'b1;
      tick();
`else
      check("rsv_fs",   32'(fs),   32'h02);
      check("rsv_rw",   32'(rw),   32'd1);
      check("rsv_done", 32'(done), 32'd1);
      tick();
      check("rsv_flag_q", 32'(flag_q),      32'b0011);
      check("rsv_ready",  32'(instr_ready), 32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
